// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings for the pipeline hazard controller
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [4:0] REG_RA  = 5'd31;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_fwd_sel: picks the forwarding source for one EX operand, MEM over WB, never $0
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       wr_mem,
  input  logic [4:0] dst_mem,
  input  logic       wr_wb,
  input  logic [4:0] dst_wb,
  output logic [1:0] fwd
);
  logic hit_mem, hit_wb;
  // match the operand against the younger (MEM) then older (WB) writer
  always_comb begin
    hit_mem = (src != 5'd0) && wr_mem && (dst_mem == src);
    hit_wb  = (src != 5'd0) && wr_wb && (dst_wb == src);
    fwd     = hit_mem ? FWD_MEM : hit_wb ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage pipe with memory-wait freeze and perf counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UseRs_ID,
  input  logic             UseRt_ID,
  input  logic [4:0]       Rs_EX,
  input  logic [4:0]       Rt_EX,
  input  logic [4:0]       Rw_EX,
  input  logic             RegWr_EX,
  input  logic             MemToReg_EX,
  input  logic [4:0]       Rw_MEM,
  input  logic [4:0]       Rw_WB,
  input  logic             RegWr_MEM,
  input  logic             RegWr_WB,
  input  logic             Jal_MEM,
  input  logic             Jal_WB,
  input  logic             OverFlow_MEM,
  input  logic             OverFlow_WB,
  input  logic             Jump_ID,
  input  logic             BrTaken_MEM,
  input  logic             MemReq_MEM,
  input  logic             MemReady,
  output logic             PC_WrEn,
  output logic             IFID_WrEn,
  output logic             IDEX_WrEn,
  output logic             EXMEM_WrEn,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             MEMWB_Flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t         state_q, state_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           lu_q, lu_d;
  logic [4:0]     dst_mem, dst_wb;
  logic           wr_mem, wr_wb, freeze, load_use;
  logic [3:0]     wr_en, flush;
  logic [1:0]     fwd_a, fwd_b;
  assign dst_mem = Jal_MEM ? REG_RA : Rw_MEM;
  assign dst_wb  = Jal_WB ? REG_RA : Rw_WB;
  assign wr_mem  = RegWr_MEM & ~OverFlow_MEM;
  assign wr_wb   = RegWr_WB & ~OverFlow_WB;
  assign freeze  = MemReq_MEM & ~MemReady;
  // a load-use stall lasts one cycle: the bubble it inserts cannot re-trigger it
  assign load_use = RegWr_EX & MemToReg_EX & (Rw_EX != 5'd0) & ~lu_q &
                    ((UseRs_ID & (Rw_EX == Rs_ID)) | (UseRt_ID & (Rw_EX == Rt_ID)));
  hazard_fwd_sel u_fwd_a (
    .src(Rs_EX), .wr_mem(wr_mem), .dst_mem(dst_mem), .wr_wb(wr_wb), .dst_wb(dst_wb), .fwd(fwd_a)
  );
  hazard_fwd_sel u_fwd_b (
    .src(Rt_EX), .wr_mem(wr_mem), .dst_mem(dst_mem), .wr_wb(wr_wb), .dst_wb(dst_wb), .fwd(fwd_b)
  );
  // next state and prioritised enables/flushes: ERR, freeze, branch, load-use, jump
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    lu_d    = 1'b0;
    wr_en   = 4'b1111;
    flush   = 4'b0000;
    if (state_q == ERR) begin
      wr_en = 4'b0000;
    end else if (freeze) begin
      wr_en   = 4'b0000;
      flush   = 4'b0001;
      state_d = (wait_q == WW'(MEM_TIMEOUT - 1)) ? ERR : MEM_WAIT;
      wait_d  = wait_q + WW'(1);
    end else begin
      state_d = RUN;
      wait_d  = '0;
      lu_d    = load_use & ~BrTaken_MEM;
      wr_en   = (load_use & ~BrTaken_MEM) ? 4'b0011 : 4'b1111;
      flush   = BrTaken_MEM ? 4'b1110 : load_use ? 4'b0100 : Jump_ID ? 4'b1000 : 4'b0000;
    end
    if (!rst_n) begin
      wr_en = 4'b0000;
      flush = 4'b1111;
    end
  end
  assign {PC_WrEn, IFID_WrEn, IDEX_WrEn, EXMEM_WrEn}       = wr_en;
  assign {IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush} = flush;
  assign ForwardA = rst_n ? fwd_a : FWD_RF;
  assign ForwardB = rst_n ? fwd_b : FWD_RF;
  assign MemErr   = (state_q == ERR);
  // state, wait counter and load-use marker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      lu_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      lu_q    <= lu_d;
    end
  end
  // saturating perf counters, frozen once the memory timeout has fired
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (state_q != ERR) begin
      if (!PC_WrEn && !(&StallCnt)) StallCnt <= StallCnt + CNT_W'(1);
      if ((IFID_Flush | IDEX_Flush | EXMEM_Flush) && !(&FlushCnt)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end
endmodule
